// File: rtl/counter_pkg.sv
// counter_pkg: shared types and defaults for the counter contact scanner.
//   dir_t        - facing / contact direction, value doubles as touch bit index
//   axis_t       - which captured coordinate a region snaps
//   region_t     - one counter-region table entry
//   REGION_TABLE - default kitchen layout (4 regions)
package counter_pkg;

  localparam int unsigned COORD_W_DEF     = 10;
  localparam int unsigned TILE_DEF        = 40;
  localparam int unsigned TILE_OFS_DEF    = 20;
  localparam int unsigned PENG_H_DEF      = 60;
  localparam int unsigned NUM_REGIONS_DEF = 4;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

  // Table coordinates are stored wide and truncated to COORD_W at the point of use.
  typedef logic [15:0] rcoord_t;

  typedef struct packed {
    dir_t    dir;
    rcoord_t px_lo;
    rcoord_t px_hi;
    rcoord_t py_lo;
    rcoord_t py_hi;
    axis_t   snap_axis;
    rcoord_t fixed_coord;
    rcoord_t snap_max;
  } region_t;

  localparam region_t REGION_TABLE [NUM_REGIONS_DEF] = '{
    '{DOWN, 16'd0,  16'd639, 16'd320, 16'd1023, AXIS_X, 16'd380, 16'd620},
    '{DOWN, 16'd60, 16'd370, 16'd160, 16'd160,  AXIS_X, 16'd220, 16'd340},
    '{UP,   16'd60, 16'd370, 16'd280, 16'd280,  AXIS_X, 16'd220, 16'd340},
    '{LEFT, 16'd0,  16'd20,  16'd0,   16'd1023, AXIS_Y, 16'd0,   16'd360}
  };

endpackage

// File: rtl/tile_snap.sv
// tile_snap: combinational snap of a coordinate onto the counter tile grid, with clamp.
//   v        in  coordinate to snap
//   snap_max in  upper clamp for the snapped value
//   result   out snapped coordinate
module tile_snap
  import counter_pkg::*;
#(
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned TILE     = TILE_DEF,
  parameter int unsigned TILE_OFS = TILE_OFS_DEF
) (
  input  logic [COORD_W-1:0] v,
  input  logic [COORD_W-1:0] snap_max,
  output logic [COORD_W-1:0] result
);

  localparam logic [COORD_W-1:0] TileC = COORD_W'(TILE);
  localparam logic [COORD_W-1:0] OfsC  = COORD_W'(TILE_OFS);

  logic [COORD_W-1:0] m;
  logic [COORD_W-1:0] base;

  always_comb begin
    m = v % TileC;
    // On a grid line the contact belongs to the tile behind it.
    base = (m == '0) ? (v - OfsC) : (v - m + OfsC);
    result = (base > snap_max) ? snap_max : base;
    if (v < OfsC) begin
      result = OfsC;
    end
  end

endmodule

// File: rtl/counter_contact_scanner.sv
// counter_contact_scanner: walks the counter region table one entry per clock after a
// start pulse and reports per-direction contact plus the snapped counter tile the
// penguin is facing.
//   Clk, Reset          clock, asynchronous active-high reset
//   start               one-cycle pulse, samples penguinX/penguinY/facing
//   penguinX, penguinY  penguin top-left position
//   facing              0=UP 1=DOWN 2=LEFT 3=RIGHT
//   busy                scan in progress
//   done                one-cycle pulse; results below are valid from this cycle on
//   touch               contact flags, bit index = direction code
//   nearestCounterX/Y   facing-direction counter tile origin, 0 when no contact
module counter_contact_scanner
  import counter_pkg::*;
#(
  parameter int unsigned COORD_W     = COORD_W_DEF,
  parameter int unsigned TILE        = TILE_DEF,
  parameter int unsigned TILE_OFS    = TILE_OFS_DEF,
  parameter int unsigned PENG_H      = PENG_H_DEF,
  parameter int unsigned NUM_REGIONS = NUM_REGIONS_DEF,
  parameter region_t     REGIONS [NUM_REGIONS] = REGION_TABLE
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] penguinX,
  input  logic [COORD_W-1:0] penguinY,
  input  logic [1:0]         facing,
  output logic               busy,
  output logic               done,
  output logic [3:0]         touch,
  output logic [COORD_W-1:0] nearestCounterX,
  output logic [COORD_W-1:0] nearestCounterY
);

  localparam int unsigned IdxW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGIONS - 1);

  // Region tables are authored against the sprite height; reject nonsense configs.
  if (NUM_REGIONS < 1 || PENG_H < 1) begin : g_bad_config
    $error("counter_contact_scanner: NUM_REGIONS and PENG_H must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

  state_t             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [1:0]         cap_facing_q, cap_facing_d;
  logic [3:0]         touch_acc_q, touch_acc_d;
  logic [COORD_W-1:0] near_x_acc_q, near_x_acc_d, near_y_acc_q, near_y_acc_d;
  logic [3:0]         touch_q, touch_d;
  logic [COORD_W-1:0] near_x_q, near_x_d, near_y_q, near_y_d;

  region_t            cur;
  logic               hit;
  logic               last;
  logic [COORD_W-1:0] snap_in, snap_res, fixed_c;

  assign cur     = REGIONS[idx_q];
  assign last    = (idx_q == LastIdx);
  assign hit     = (cap_x_q >= COORD_W'(cur.px_lo)) && (cap_x_q <= COORD_W'(cur.px_hi)) &&
                   (cap_y_q >= COORD_W'(cur.py_lo)) && (cap_y_q <= COORD_W'(cur.py_hi));
  assign snap_in = (cur.snap_axis == AXIS_X) ? cap_x_q : cap_y_q;
  assign fixed_c = COORD_W'(cur.fixed_coord);

  tile_snap #(
    .COORD_W  (COORD_W),
    .TILE     (TILE),
    .TILE_OFS (TILE_OFS)
  ) u_tile_snap (
    .v        (snap_in),
    .snap_max (COORD_W'(cur.snap_max)),
    .result   (snap_res)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start outside StIdle is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = (state_q == StScan);
    done = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    idx_d        = idx_q;
    cap_x_d      = cap_x_q;
    cap_y_d      = cap_y_q;
    cap_facing_d = cap_facing_q;
    touch_acc_d  = touch_acc_q;
    near_x_acc_d = near_x_acc_q;
    near_y_acc_d = near_y_acc_q;
    touch_d      = touch_q;
    near_x_d     = near_x_q;
    near_y_d     = near_y_q;

    if (state_q == StIdle && start) begin
      cap_x_d      = penguinX;
      cap_y_d      = penguinY;
      cap_facing_d = facing;
      touch_acc_d  = '0;
      near_x_acc_d = '0;
      near_y_acc_d = '0;
      idx_d        = '0;
    end else if (state_q == StScan) begin
      // First hit per direction wins, so earlier table entries take priority.
      if (hit && !touch_acc_q[cur.dir]) begin
        touch_acc_d[cur.dir] = 1'b1;
        if (cur.dir == cap_facing_q) begin
          near_x_acc_d = (cur.snap_axis == AXIS_X) ? snap_res : fixed_c;
          near_y_acc_d = (cur.snap_axis == AXIS_X) ? fixed_c : snap_res;
        end
      end
      if (last) begin
        // Publish on entry to StDone so results are valid while done is high.
        touch_d  = touch_acc_d;
        near_x_d = near_x_acc_d;
        near_y_d = near_y_acc_d;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q        <= '0;
      cap_x_q      <= '0;
      cap_y_q      <= '0;
      cap_facing_q <= '0;
      touch_acc_q  <= '0;
      near_x_acc_q <= '0;
      near_y_acc_q <= '0;
      touch_q      <= '0;
      near_x_q     <= '0;
      near_y_q     <= '0;
    end else begin
      idx_q        <= idx_d;
      cap_x_q      <= cap_x_d;
      cap_y_q      <= cap_y_d;
      cap_facing_q <= cap_facing_d;
      touch_acc_q  <= touch_acc_d;
      near_x_acc_q <= near_x_acc_d;
      near_y_acc_q <= near_y_acc_d;
      touch_q      <= touch_d;
      near_x_q     <= near_x_d;
      near_y_q     <= near_y_d;
    end
  end

  assign touch           = touch_q;
  assign nearestCounterX = near_x_q;
  assign nearestCounterY = near_y_q;

endmodule
